// File: rtl/accumulator_pkg.sv
// Shared constants and the result word layout for the I/Q frame accumulator.
package accumulator_pkg;

  localparam int LANE_W  = 48;            // width of each I/Q lane on the stream
  localparam int SUM_W   = 32;            // width of each running sum
  localparam int INDEX_W = 10;            // sample index width
  localparam int DEPTH   = 1 << INDEX_W;  // entries in the sum storage
  localparam int WORD_W  = 2 * SUM_W;     // one storage / result word
  localparam int FRAME_W = 16;            // frame counter width (NUM_FRAMES <= 65535)

  typedef logic signed [SUM_W-1:0] sum_t;

  // Result and storage word: Q sum in the upper half, I sum in the lower half.
  typedef struct packed {
    sum_t q;
    sum_t i;
  } result_word_t;

endpackage

// File: rtl/accumulator_ram.sv
// 1024 x 64 sum storage: one synchronous write port, combinational read port.
// A write lands on the same edge that accepts the beat, so the following
// cycle already reads the updated sum.
module accumulator_ram
  import accumulator_pkg::*;
(
  input  logic               clk,
  input  logic               we,
  input  logic [INDEX_W-1:0] waddr,
  input  logic [WORD_W-1:0]  wdata,
  input  logic [INDEX_W-1:0] raddr,
  output logic [WORD_W-1:0]  rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  // Store the updated sum for the accepted beat.
  // NOTE: the storage array has no reset; frame 0 of every period overwrites
  // each entry before it is read, so clearing it would only cost logic.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/accumulator.sv
// Sums the I and Q lanes of NUM_FRAMES consecutive frames per sample index
// and emits one {Q,I} result word per sample during the last frame.
module accumulator
  import accumulator_pkg::*;
#(
  parameter int NUM_FRAMES = 16
) (
  input  logic        s00_axis_aclk_0,
  input  logic        s00_axis_aresetn_0,
  input  logic [95:0] S00_AXIS_0_tdata,
  input  logic        S00_AXIS_0_tvalid,
  input  logic        S00_AXIS_0_tlast,
  input  logic [11:0] S00_AXIS_0_tstrb,
  output logic        S00_AXIS_0_tready,
  output logic [9:0]  result_bram_addr_write_0,
  output logic [63:0] result_bram_dataout_0,
  output logic        result_bram_w_enable_0
);

  localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(NUM_FRAMES - 1);
  localparam logic [INDEX_W-1:0] LAST_INDEX = INDEX_W'(DEPTH - 1);

  logic               clk;
  logic               rst_n;
  logic [INDEX_W-1:0] sample_idx;
  logic [FRAME_W-1:0] frame_cnt;
  logic               accept;
  logic               frame_end;
  logic               last_frame;
  sum_t               lane_i;
  sum_t               lane_q;
  result_word_t       rd_word;
  result_word_t       new_word;
  logic [WORD_W-1:0]  ram_rdata;
  logic               unused_bits;

  assign clk   = s00_axis_aclk_0;
  assign rst_n = s00_axis_aresetn_0;

  // Always ready outside reset; the sink never back-pressures.
  assign S00_AXIS_0_tready = rst_n;

  assign accept     = S00_AXIS_0_tvalid & S00_AXIS_0_tready;
  assign frame_end  = S00_AXIS_0_tlast | (sample_idx == LAST_INDEX);
  assign last_frame = (frame_cnt == LAST_FRAME);

  // Only the low 32 bits of each lane contribute; upper lane bits and strobes are dropped.
  assign lane_i      = S00_AXIS_0_tdata[SUM_W-1:0];
  assign lane_q      = S00_AXIS_0_tdata[LANE_W+SUM_W-1:LANE_W];
  assign unused_bits = ^{S00_AXIS_0_tstrb,
                         S00_AXIS_0_tdata[LANE_W-1:SUM_W],
                         S00_AXIS_0_tdata[2*LANE_W-1:LANE_W+SUM_W]};

  assign rd_word = result_word_t'(ram_rdata);

  // Updated sum: frame 0 restarts the period, later frames add onto the stored sum.
  // NOTE: the default assignment first keeps every path of this block driven,
  // so no latch is inferred.
  always_comb begin
    new_word = '0;
    if (frame_cnt == '0) begin
      new_word.i = lane_i;
      new_word.q = lane_q;
    end else begin
      new_word.i = rd_word.i + lane_i;
      new_word.q = rd_word.q + lane_q;
    end
  end

  accumulator_ram u_ram (
    .clk   (clk),
    .we    (accept),
    .waddr (sample_idx),
    .wdata (new_word),
    .raddr (sample_idx),
    .rdata (ram_rdata)
  );

  // Sample index and frame counter advance on accepted beats only.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_idx <= '0;
      frame_cnt  <= '0;
    end else if (accept) begin
      if (frame_end) begin
        sample_idx <= '0;
        frame_cnt  <= last_frame ? '0 : frame_cnt + 1'b1;
      end else begin
        sample_idx <= sample_idx + 1'b1;
      end
    end
  end

  // Registered result write, one cycle after each accepted beat of the last frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_bram_w_enable_0   <= 1'b0;
      result_bram_addr_write_0 <= '0;
      result_bram_dataout_0    <= '0;
    end else begin
      result_bram_w_enable_0 <= accept & last_frame;
      if (accept && last_frame) begin
        result_bram_addr_write_0 <= sample_idx;
        result_bram_dataout_0    <= new_word;
      end
    end
  end

endmodule

// File: tb/tb_accumulator.sv
// Directed bench for the accumulator: three instances (NUM_FRAMES = 16, 1, 4)
// share one stimulus stream; each scenario resets first and checks only the
// instance it targets.
module tb_accumulator;

  logic        clk;
  logic        rst_n;
  logic [95:0] tdata;
  logic        tvalid;
  logic        tlast;
  logic [11:0] tstrb;

  logic        tready_16, tready_1, tready_4;
  logic [9:0]  addr_16, addr_1, addr_4;
  logic [63:0] data_16, data_1, data_4;
  logic        we_16, we_1, we_4;

  int n_errors = 0;
  int n_checks = 0;

  accumulator #(.NUM_FRAMES(16)) dut_16 (
    .s00_axis_aclk_0          (clk),
    .s00_axis_aresetn_0       (rst_n),
    .S00_AXIS_0_tdata         (tdata),
    .S00_AXIS_0_tvalid        (tvalid),
    .S00_AXIS_0_tlast         (tlast),
    .S00_AXIS_0_tstrb         (tstrb),
    .S00_AXIS_0_tready        (tready_16),
    .result_bram_addr_write_0 (addr_16),
    .result_bram_dataout_0    (data_16),
    .result_bram_w_enable_0   (we_16)
  );

  accumulator #(.NUM_FRAMES(1)) dut_1 (
    .s00_axis_aclk_0          (clk),
    .s00_axis_aresetn_0       (rst_n),
    .S00_AXIS_0_tdata         (tdata),
    .S00_AXIS_0_tvalid        (tvalid),
    .S00_AXIS_0_tlast         (tlast),
    .S00_AXIS_0_tstrb         (tstrb),
    .S00_AXIS_0_tready        (tready_1),
    .result_bram_addr_write_0 (addr_1),
    .result_bram_dataout_0    (data_1),
    .result_bram_w_enable_0   (we_1)
  );

  accumulator #(.NUM_FRAMES(4)) dut_4 (
    .s00_axis_aclk_0          (clk),
    .s00_axis_aresetn_0       (rst_n),
    .S00_AXIS_0_tdata         (tdata),
    .S00_AXIS_0_tvalid        (tvalid),
    .S00_AXIS_0_tlast         (tlast),
    .S00_AXIS_0_tstrb         (tstrb),
    .S00_AXIS_0_tready        (tready_4),
    .result_bram_addr_write_0 (addr_4),
    .result_bram_dataout_0    (data_4),
    .result_bram_w_enable_0   (we_4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One cycle of stimulus driven at the falling edge; returns 1 time unit after the next rising edge.
  task automatic drive(input logic v, input logic [47:0] i_lane, input logic [47:0] q_lane, input logic last);
    @(negedge clk);
    tvalid = v;
    tdata  = {q_lane, i_lane};
    tlast  = last;
    tstrb  = 12'($urandom);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    drive(1'b0, 48'h0, 48'h0, 1'b0);
  endtask

  // Reset for a few cycles, checking every instance's outputs while held.
  task automatic apply_reset();
    @(negedge clk);
    rst_n  = 1'b0;
    tvalid = 1'b0;
    tlast  = 1'b0;
    tdata  = '0;
    #1;
    for (int c = 0; c < 2; c++) begin
      check("rst_tready_16", 64'(tready_16), 64'd0);
      check("rst_we_16",     64'(we_16),     64'd0);
      check("rst_addr_16",   64'(addr_16),   64'd0);
      check("rst_data_16",   data_16,        64'd0);
      check("rst_we_1",      64'(we_1),      64'd0);
      check("rst_data_1",    data_1,         64'd0);
      check("rst_we_4",      64'(we_4),      64'd0);
      check("rst_data_4",    data_4,         64'd0);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("tready_16_after_reset", 64'(tready_16), 64'd1);
    check("tready_1_after_reset",  64'(tready_1),  64'd1);
  endtask

  // One averaging period on the NUM_FRAMES=16 instance: beat n carries 0x400*(n+1) on both lanes.
  // gap_last inserts an idle cycle before every beat of frame 15; stop_at >= 0 leaves frame 15 before beat stop_at.
  task automatic run_period(input bit gap_last, input int stop_at);
    int strobes;
    logic [31:0] exp_sum;
    strobes = 0;
    for (int f = 0; f < 16; f++) begin
      for (int n = 0; n < 1024; n++) begin
        if (f == 15 && n == stop_at) return;
        if (gap_last && f == 15) begin
          idle_cycle();
          check("gap_we", 64'(we_16), 64'd0);
        end
        drive(1'b1, 48'(32'h400 * (n + 1)), 48'(32'h400 * (n + 1)), n == 1023);
        strobes += int'(we_16);
        if (f == 15) begin
          exp_sum = 32'h4000 * (n + 1);
          check("period_we",   64'(we_16),   64'd1);
          check("period_addr", 64'(addr_16), 64'(n));
          check("period_data", data_16,      {exp_sum, exp_sum});
        end else begin
          check("early_frame_we", 64'(we_16), 64'd0);
        end
      end
    end
    check("period_strobe_count", 64'(strobes), 64'd1024);
  endtask

  initial begin
    rst_n  = 1'b1;
    tvalid = 1'b0;
    tlast  = 1'b0;
    tdata  = '0;
    tstrb  = '0;

    apply_reset();

    // NUM_FRAMES=1: two 4-beat frames pass straight through, short frame leaves no other writes.
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < 4; k++) begin
        drive(1'b1, 48'(k + 1), 48'(k + 1), k == 3);
        check("pass_we",   64'(we_1),   64'd1);
        check("pass_addr", 64'(addr_1), 64'(k));
        check("pass_data", data_1,      {32'(k + 1), 32'(k + 1)});
      end
    end
    idle_cycle();
    check("pass_idle_we",   64'(we_1),   64'd0);
    check("pass_idle_addr", 64'(addr_1), 64'd3);
    check("pass_idle_data", data_1,      {32'd4, 32'd4});
    check("short_frames_no_write_16", 64'(we_16), 64'd0);

    apply_reset();

    // NUM_FRAMES=4: back-to-back one-beat frames must read the just-written sum.
    for (int f = 0; f < 4; f++) begin
      drive(1'b1, 48'hFFFF_FFFF_FFFF, 48'd5, 1'b1);
      check("fwd_we", 64'(we_4), (f == 3) ? 64'd1 : 64'd0);
    end
    check("fwd_addr", 64'(addr_4), 64'd0);
    check("fwd_data", data_4,      {32'h0000_0014, 32'hFFFF_FFFC});
    idle_cycle();
    check("fwd_idle_we", 64'(we_4), 64'd0);

    apply_reset();

    // Full period, then a second period with a gappy last frame: identical results.
    run_period(1'b0, -1);
    run_period(1'b1, -1);

    // Reset in the middle of frame 15, then a clean period.
    run_period(1'b0, 500);
    apply_reset();
    run_period(1'b0, -1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
